// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_ctrl : PC owner and instruction-fetch sequencer (mem req/ack ->   |
// |                 decode valid/ready) with branch redirect and fetch squash. |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module pc_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_rdata,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic                r_kill, w_kill_nxt;
  logic                w_req_nxt, w_valid_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt, w_ifpc_nxt;
  logic [31:0]         w_instr_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt, w_cnt_sat;
  logic [ADDR_W-1:0]   w_br_tgt;

  assign w_br_tgt  = {br_target[ADDR_W-1:2], 2'b00};
  assign w_cnt_sat = (&fetch_cnt) ? fetch_cnt : fetch_cnt + C_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_VEC;
      r_kill    <= 1'b0;
      im_req    <= 1'b0;
      im_addr   <= RESET_VEC;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      fetch_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_kill    <= w_kill_nxt;
      im_req    <= w_req_nxt;
      im_addr   <= w_addr_nxt;
      if_valid  <= w_valid_nxt;
      if_instr  <= w_instr_nxt;
      if_pc     <= w_ifpc_nxt;
      fetch_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_req_nxt   = im_req;
    w_addr_nxt  = im_addr;
    w_valid_nxt = if_valid;
    w_instr_nxt = if_instr;
    w_ifpc_nxt  = if_pc;
    w_cnt_nxt   = fetch_cnt;
    case (r_state)
      ST_BOOT: begin
        if (br_valid) w_pc_nxt = w_br_tgt;
        w_state_nxt = ST_FETCH;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = w_pc_nxt;
      end
      ST_FETCH: begin
        if (im_ack) begin
          if (r_kill || br_valid) begin
            // Returned word belongs to a redirected-away path: drop it and re-request.
            w_kill_nxt = 1'b0;
            if (br_valid) w_pc_nxt = w_br_tgt;
            w_addr_nxt = w_pc_nxt;
          end else begin
            w_instr_nxt = im_rdata;
            w_ifpc_nxt  = r_pc;
            w_pc_nxt    = r_pc + C_PC_STEP;
            w_state_nxt = ST_HOLD;
            w_req_nxt   = 1'b0;
            w_valid_nxt = 1'b1;
          end
        end else if (br_valid) begin
          // The request on the bus cannot be withdrawn; mark its ack for discard.
          w_pc_nxt   = w_br_tgt;
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (id_ready || br_valid) begin
          if (id_ready) w_cnt_nxt = w_cnt_sat;
          if (br_valid) w_pc_nxt = w_br_tgt;
          w_state_nxt = ST_FETCH;
          w_valid_nxt = 1'b0;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_pc_nxt;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

endmodule
`default_nettype wire
